// File: rtl/stabilizer_array.sv
// Multi-channel input stabilizer: per-channel synchroniser, saturating stability filter,
// and registered rise/fall/long-press event pulses.
module stabilizer_array #(
  parameter int CHANNELS       = 4,
  parameter int SYNC_DEPTH     = 3,
  parameter int LENGTH_IN_BITS = 4,
  parameter int HOLD_IN_BITS   = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold,
  output logic                any_event
);

  localparam logic [LENGTH_IN_BITS-1:0] LEN_MAX  = '1;
  localparam logic [LENGTH_IN_BITS-1:0] LEN_ONE  = {{(LENGTH_IN_BITS-1){1'b0}}, 1'b1};
  localparam logic [HOLD_IN_BITS-1:0]   HOLD_MAX = '1;
  localparam logic [HOLD_IN_BITS-1:0]   HOLD_ONE = {{(HOLD_IN_BITS-1){1'b0}}, 1'b1};
  localparam logic [HOLD_IN_BITS-1:0]   HOLD_PRE = HOLD_MAX - HOLD_ONE;

  logic [CHANNELS-1:0] r_sync [SYNC_DEPTH];
  logic [CHANNELS-1:0] w_in_s;

  // Synchroniser chain; the last stage is the filter input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_DEPTH; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= in;
      for (int s = 1; s < SYNC_DEPTH; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_in_s = r_sync[SYNC_DEPTH-1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic                      r_cand;
    logic [LENGTH_IN_BITS-1:0] r_cnt;
    logic                      r_out;
    logic                      r_rise;
    logic                      r_fall;
    logic                      r_hold;
    logic [HOLD_IN_BITS-1:0]   r_hcnt;

    logic                      w_cand_nxt;
    logic [LENGTH_IN_BITS-1:0] w_cnt_nxt;
    logic                      w_out_nxt;
    logic [HOLD_IN_BITS-1:0]   w_hcnt_nxt;
    logic                      w_hold_nxt;

    // Stability filter: out follows cand only once the count has saturated.
    always_comb begin
      w_cand_nxt = r_cand;
      w_cnt_nxt  = r_cnt;
      w_out_nxt  = r_out;
      if (w_in_s[g] != r_cand) begin
        w_cand_nxt = w_in_s[g];
        w_cnt_nxt  = '0;
      end else if (r_cnt != LEN_MAX) begin
        w_cnt_nxt = r_cnt + LEN_ONE;
      end else begin
        w_out_nxt = r_cand;
      end
    end

    // Hold counter runs only across edges where out stays 1, so rise and fall both clear it.
    always_comb begin
      w_hcnt_nxt = '0;
      w_hold_nxt = 1'b0;
      if (r_out && w_out_nxt) begin
        if (r_hcnt != HOLD_MAX) begin
          w_hcnt_nxt = r_hcnt + HOLD_ONE;
          w_hold_nxt = (r_hcnt == HOLD_PRE);
        end else begin
          w_hcnt_nxt = r_hcnt;
        end
      end else begin
        w_hcnt_nxt = '0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cand <= 1'b0;
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_hold <= 1'b0;
        r_hcnt <= '0;
      end else begin
        r_cand <= w_cand_nxt;
        r_cnt  <= w_cnt_nxt;
        r_out  <= w_out_nxt;
        r_rise <= ~r_out & w_out_nxt;
        r_fall <= r_out & ~w_out_nxt;
        r_hold <= w_hold_nxt;
        r_hcnt <= w_hcnt_nxt;
      end
    end

    assign out[g]  = r_out;
    assign rise[g] = r_rise;
    assign fall[g] = r_fall;
    assign hold[g] = r_hold;
  end

  assign any_event = |{rise, fall, hold};

endmodule

// File: tb/tb_stabilizer_array.sv
// Self-checking bench for stabilizer_array: a sliding-window reference model compared every
// cycle, plus directed latency/count checks with hand-derived expectations.
module tb_stabilizer_array;

  localparam int CH   = 4;
  localparam int HB   = 4;
  localparam int WIN  = 17;              // consecutive samples needed for out to move
  localparam int HMAX = (1 << HB) - 1;   // edges of out=1 before a hold pulse

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] in;
  logic [CH-1:0] out, rise, fall, hold;
  logic          any_event;

  stabilizer_array #(
    .CHANNELS(CH), .SYNC_DEPTH(3), .LENGTH_IN_BITS(4), .HOLD_IN_BITS(HB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in(in), .out(out),
    .rise(rise), .fall(fall), .hold(hold), .any_event(any_event)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  // Model state: samples of `in` at the last 20 edges (index 19 = newest).
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_out, m_rise, m_fall, m_hold;
  int            m_run [CH];

  // Observed-event log for directed checks.
  int rise_cnt [CH];
  int fall_cnt [CH];
  int hold_cnt [CH];
  int last_rise[CH];
  int last_hold[CH];
  int any_cnt  = 0;
  int last_any = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: out moves to v once the input has been sampled as v on 17
  // consecutive edges, delayed by the 3-stage synchroniser and the candidate stage.
  initial begin
    for (int k = 0; k < 20; k++) hist.push_back('0);
    m_out = '0; m_rise = '0; m_fall = '0; m_hold = '0;
    for (int c = 0; c < CH; c++) m_run[c] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        for (int k = 0; k < 20; k++) hist[k] = '0;
        m_out = '0; m_rise = '0; m_fall = '0; m_hold = '0;
        for (int c = 0; c < CH; c++) m_run[c] = 0;
      end else begin
        hist.push_back(in);
        hist.delete(0);
        for (int c = 0; c < CH; c++) begin
          bit all1, all0, nv;
          all1 = 1'b1; all0 = 1'b1;
          for (int k = 0; k < WIN; k++) begin
            if (hist[k][c]) all0 = 1'b0;
            else            all1 = 1'b0;
          end
          nv = all1 ? 1'b1 : (all0 ? 1'b0 : m_out[c]);
          m_rise[c] = !m_out[c] && nv;
          m_fall[c] = m_out[c] && !nv;
          if (m_out[c] && nv) m_run[c]++;
          else                m_run[c] = 0;
          m_hold[c] = m_out[c] && nv && (m_run[c] == HMAX);
          m_out[c]  = nv;
        end
      end
    end
  end

  // Per-cycle compare against the model, then log observed events.
  initial begin
    for (int c = 0; c < CH; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; hold_cnt[c] = 0;
      last_rise[c] = -1; last_hold[c] = -1;
    end
    forever begin
      logic [4*CH:0] exp_v;
      @(negedge clk);
      if (!reset_n) exp_v = '0;
      else exp_v = {m_out, m_rise, m_fall, m_hold, |{m_rise, m_fall, m_hold}};
      chk($sformatf("cycle%0d_outputs", cyc),
          longint'({out, rise, fall, hold, any_event}), longint'(exp_v));
      for (int c = 0; c < CH; c++) begin
        if (rise[c]) begin rise_cnt[c]++; last_rise[c] = cyc; end
        if (fall[c]) fall_cnt[c]++;
        if (hold[c]) begin hold_cnt[c]++; last_hold[c] = cyc; end
      end
      if (any_event) begin any_cnt++; last_any = cyc; end
    end
  end

  initial begin
    int t0, tl, r0, f0, h0, a0, rsum;
    int p;
    in = '0;
    reset_n = 1'b0;
    step(3);
    chk("reset_outputs", longint'({out, rise, fall, hold, any_event}), 64'd0);
    reset_n = 1'b1;
    step(30);

    // Clean step on channel 0, then keep it pressed for the long-press pulse.
    rsum = rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
    f0 = fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3];
    in[0] = 1'b1; t0 = cyc;
    step(25);
    chk("step_rise_time", last_rise[0], t0 + 20);
    chk("step_rise_count", rise_cnt[0], 1);
    chk("step_other_rises", rise_cnt[1] + rise_cnt[2] + rise_cnt[3], rsum);
    chk("step_no_fall", fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3], f0);
    step(40);
    chk("hold_time", last_hold[0], t0 + 20 + 15);
    chk("hold_count", hold_cnt[0], 1);
    in[0] = 1'b0;
    step(30);
    chk("release_fall", fall_cnt[0], 1);

    // Bounce on channel 1: toggle every 3 cycles, 13 toggles ending high.
    r0 = rise_cnt[1]; tl = 0;
    for (int k = 0; k < 13; k++) begin
      in[1] = ~in[1]; tl = cyc;
      step(3);
    end
    chk("bounce_quiet", rise_cnt[1], r0);
    step(25);
    chk("bounce_rise_time", last_rise[1], tl + 20);
    chk("bounce_rise_count", rise_cnt[1], r0 + 1);
    in = '0;
    step(30);

    // All four channels rise together.
    a0 = any_cnt;
    in = 4'b1111; t0 = cyc;
    step(25);
    for (int c = 0; c < CH; c++) chk($sformatf("simul_rise%0d", c), last_rise[c], t0 + 20);
    chk("simul_any_time", last_any, t0 + 20);
    chk("simul_any_count", any_cnt, a0 + 1);
    step(20);
    in = 4'b1000;
    step(30);

    // Reset ten cycles into the filter of channel 2 while channel 3 is high.
    chk("pre_reset_out", longint'(out), 64'h8);
    in = 4'b1100; t0 = cyc;
    step(10);
    #2 reset_n = 1'b0;
    #1 chk("reset_mid_outputs", longint'({out, rise, fall, hold, any_event}), 64'd0);
    step(3);
    reset_n = 1'b1; t0 = cyc;
    step(25);
    chk("post_reset_rise2", last_rise[2], t0 + 20);
    chk("post_reset_rise3", last_rise[3], t0 + 20);
    in = '0;
    step(30);

    // Long press: saturated counters must not re-fire.
    r0 = rise_cnt[0]; h0 = hold_cnt[0]; f0 = fall_cnt[0];
    in[0] = 1'b1;
    step(1000);
    chk("sat_rise_count", rise_cnt[0], r0 + 1);
    chk("sat_hold_count", hold_cnt[0], h0 + 1);
    chk("sat_no_fall", fall_cnt[0], f0);
    in = '0;
    step(30);

    // Random stimulus: alternate glitchy and slow phases, with one reset in the middle.
    for (int n = 0; n < 4000; n++) begin
      p = ((n / 400) % 2 == 0) ? 3 : 30;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, p) == 0) in[c] = ~in[c];
      end
      if (n == 2000) reset_n = 1'b0;
      if (n == 2003) reset_n = 1'b1;
      step(1);
    end
    in = '0;
    step(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
